quarter_wave_dds: RTL and testbench

Parametrised I/Q direct digital synthesiser for the modulator datapath. A phase accumulator with programmable increment and phase offset drives a single quarter-wave sine LUT. Quadrant folding produces simultaneous sine and cosine samples. The block issues one sample per enabled cycle and feeds the mixer and up-converter stages with a valid-qualified packed {cos, sin} word.

---
 rtl/quarter_wave_dds_if.sv | 25 ++
 rtl/quarter_wave_dds.sv | 117 +++++++++++
 tb/tb_quarter_wave_dds.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quarter_wave_dds_if.sv
// Configuration, control and sample bus of the quarter-wave I/Q DDS.
// The master drives configuration and control; the slave (the DDS) returns samples.
interface quarter_wave_dds_if #(
  parameter int PHACCWIDTH = 32,
  parameter int OWIDTH     = 32
);
  logic [PHACCWIDTH-1:0] phInc;
  logic                  valPhInc;
  logic [PHACCWIDTH-1:0] phOffs;
  logic                  valPhOffs;
  logic                  enable;
  logic                  syncClr;
  logic [OWIDTH-1:0]     dOut;
  logic                  valOut;

  modport master (
    output phInc, valPhInc, phOffs, valPhOffs, enable, syncClr,
    input  dOut, valOut
  );

  modport slave (
    input  phInc, valPhInc, phOffs, valPhOffs, enable, syncClr,
    output dOut, valOut
  );
endinterface

// File: rtl/quarter_wave_dds.sv
// I/Q DDS: phase accumulator with offset, quadrant folding into one quarter-wave
// sine ROM with two read ports; packed {cos, sin} output after a fixed 3-cycle latency.
module quarter_wave_dds #(
  parameter int    PHACCWIDTH   = 32,
  parameter int    LUTADDRWIDTH = 8,
  parameter int    AMPWIDTH     = 16,
  parameter int    OWIDTH       = 2*AMPWIDTH,
  parameter string LUTFILE      = "quarter_sine_lut.txt"
) (
  input  logic              clk,
  input  logic              reset,
  quarter_wave_dds_if.slave bus
);

  localparam int  DEPTH = 1 << LUTADDRWIDTH;
  localparam int  TOPW  = LUTADDRWIDTH + 2;
  localparam real PI    = 3.14159265358979323846;

  // ROM contents are elaborated from the same formula that generates LUTFILE.
  function automatic logic [AMPWIDTH-1:0] lut_entry(input int k);
    real peak;
    real x;
    peak = real'((1 << (AMPWIDTH-1)) - 1);
    x    = peak * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(DEPTH));
    return AMPWIDTH'($rtoi(x + 0.5));
  endfunction

  logic [AMPWIDTH-1:0] lut_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    assign lut_rom[k] = lut_entry(k);
  end

  logic [PHACCWIDTH-1:0]   ph_acc;
  logic [PHACCWIDTH-1:0]   ph_inc_reg;
  logic [PHACCWIDTH-1:0]   ph_off_reg;
  logic [PHACCWIDTH-1:0]   acc_base;
  logic [PHACCWIDTH-1:0]   phase;
  logic [TOPW-1:0]         phase_top;
  logic                    unused_phase_lsbs;

  logic                    v1;
  logic [TOPW-1:0]         p1;
  logic [1:0]              q_sin;
  logic [1:0]              q_cos;
  logic [LUTADDRWIDTH-1:0] a_fold;

  logic                    v2;
  logic [LUTADDRWIDTH-1:0] sin_addr;
  logic [LUTADDRWIDTH-1:0] cos_addr;
  logic                    sin_neg;
  logic                    cos_neg;

  logic [AMPWIDTH-1:0]     sin_mag;
  logic [AMPWIDTH-1:0]     cos_mag;
  logic [AMPWIDTH-1:0]     sin_val;
  logic [AMPWIDTH-1:0]     cos_val;
  logic [OWIDTH-1:0]       dout_next;

  always_comb begin
    acc_base  = bus.syncClr ? '0 : ph_acc;
    phase     = acc_base + ph_off_reg;
    phase_top = phase[PHACCWIDTH-1 -: TOPW];
  end

  // Phase bits below the ROM address are truncated.
  assign unused_phase_lsbs = ^phase[PHACCWIDTH-TOPW-1:0];

  assign q_sin  = p1[TOPW-1 -: 2];
  assign q_cos  = q_sin + 2'd1;
  assign a_fold = p1[LUTADDRWIDTH-1:0];

  always_comb begin
    sin_mag   = lut_rom[sin_addr];
    cos_mag   = lut_rom[cos_addr];
    sin_val   = sin_neg ? (AMPWIDTH'(0) - sin_mag) : sin_mag;
    cos_val   = cos_neg ? (AMPWIDTH'(0) - cos_mag) : cos_mag;
    dout_next = {cos_val, sin_val};
  end

  // ROM read and negation share the final register so the latency stays at 3.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ph_acc     <= '0;
      ph_inc_reg <= '0;
      ph_off_reg <= '0;
      v1         <= 1'b0;
      p1         <= '0;
      v2         <= 1'b0;
      sin_addr   <= '0;
      cos_addr   <= '0;
      sin_neg    <= 1'b0;
      cos_neg    <= 1'b0;
      bus.valOut <= 1'b0;
      bus.dOut   <= '0;
    end else begin
      if (bus.valPhInc)  ph_inc_reg <= bus.phInc;
      if (bus.valPhOffs) ph_off_reg <= bus.phOffs;

      if (bus.syncClr)     ph_acc <= bus.enable ? ph_inc_reg : '0;
      else if (bus.enable) ph_acc <= ph_acc + ph_inc_reg;

      v1 <= bus.enable;
      if (bus.enable) p1 <= phase_top;

      v2       <= v1;
      sin_addr <= q_sin[0] ? ~a_fold : a_fold;
      cos_addr <= q_cos[0] ? ~a_fold : a_fold;
      sin_neg  <= q_sin[1];
      cos_neg  <= q_cos[1];

      bus.valOut <= v2;
      if (v2) bus.dOut <= dout_next;
    end
  end

endmodule

// File: tb/tb_quarter_wave_dds.sv
// Scoreboard bench for quarter_wave_dds: the driver queues expected samples with their
// due cycle, a negedge monitor pops and compares whenever valOut is high.
`timescale 1ns/1ps
module tb_quarter_wave_dds;
  localparam int  PW = 32;
  localparam int  AW = 16;
  localparam int  OW = 32;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    logic [OW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_s;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t          sb[$];
  logic [OW-1:0] cap[$];
  logic [OW-1:0] last_dout = '0;
  logic [15:0]   save_cos [1024];

  logic [PW-1:0] m_acc = '0;
  logic [PW-1:0] m_inc = '0;
  logic [PW-1:0] m_off = '0;
  logic [OW-1:0] hand_val = '0;
  bit            hand_en = 1'b0;

  always #5 clk = ~clk;

  quarter_wave_dds_if #(.PHACCWIDTH(PW), .OWIDTH(OW)) bus ();

  quarter_wave_dds #(
    .PHACCWIDTH(PW), .LUTADDRWIDTH(8), .AMPWIDTH(AW), .OWIDTH(OW)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst_n;
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int lut_val(int k);
    real x;
    x = 32767.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / 256.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic logic [15:0] fold(logic [1:0] q, logic [7:0] a);
    logic [7:0]  idx;
    logic [15:0] m;
    logic [15:0] r;
    idx = q[0] ? ~a : a;
    m   = 16'(lut_val(int'(idx)));
    r   = q[1] ? (16'd0 - m) : m;
    return r;
  endfunction

  function automatic logic [OW-1:0] model_word(logic [PW-1:0] p);
    logic [1:0] q;
    logic [1:0] qc;
    logic [7:0] a;
    q  = p[31:30];
    qc = q + 2'd1;
    a  = p[29:22];
    return {fold(qc, a), fold(q, a)};
  endfunction

  task automatic set_hand(input logic [OW-1:0] v);
    hand_val = v;
    hand_en  = 1'b1;
  endtask

  // One clock cycle: apply controls, advance the reference model, queue the expectation.
  task automatic tick(input logic en, input logic sc);
    logic [PW-1:0] p;
    exp_t          e;
    bus.enable  = en;
    bus.syncClr = sc;
    if (!rst_n) begin
      m_acc = '0;
      m_inc = '0;
      m_off = '0;
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    end else begin
      if (en) begin
        p      = (sc ? '0 : m_acc) + m_off;
        e.data = hand_en ? hand_val : model_word(p);
        e.due  = cyc + 3;
        sb.push_back(e);
      end
      if (sc)      m_acc = en ? m_inc : '0;
      else if (en) m_acc = m_acc + m_inc;
      if (bus.valPhInc)  m_inc = bus.phInc;
      if (bus.valPhOffs) m_off = bus.phOffs;
    end
    hand_en = 1'b0;
    @(posedge clk);
    #1;
    bus.enable    = 1'b0;
    bus.syncClr   = 1'b0;
    bus.valPhInc  = 1'b0;
    bus.valPhOffs = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1'b0, 1'b0);
    if (sb.size() > 0) begin
      chk("drain_timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_s === 1'b0) begin
      chk("reset_valOut", 64'(bus.valOut), 64'd0);
      chk("reset_dOut", 64'(bus.dOut), 64'd0);
      last_dout = '0;
    end else if (rst_s === 1'b1) begin
      if (bus.valOut === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_valOut_queue_len", 64'd1, 64'(sb.size()));
        end else begin
          e = sb.pop_front();
          chk("sample_dOut", 64'(bus.dOut), 64'(e.data));
          chk("sample_latency_cycle", 64'(cyc), 64'(e.due));
        end
        cap.push_back(bus.dOut);
        last_dout = bus.dOut;
      end else begin
        chk("idle_valOut_known", 64'(bus.valOut), 64'd0);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          chk("missing_valOut_due", 64'(cyc), 64'(e.due));
        end
        chk("hold_dOut", 64'(bus.dOut), 64'(last_dout));
      end
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] w;
    logic [OW-1:0] w2;
    logic [15:0]   neg;
    int            mx;
    int            s;
    logic [4:0]    gap_pat;

    rst_n         = 1'b0;
    bus.phInc     = '0;
    bus.valPhInc  = 1'b0;
    bus.phOffs    = '0;
    bus.valPhOffs = 1'b0;
    bus.enable    = 1'b0;
    bus.syncClr   = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with enable high: nothing may come out.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);

    // One LUT index per sample over a full period plus the wrap sample.
    bus.phInc = 32'h0040_0000; bus.valPhInc = 1'b1;
    bus.phOffs = '0;           bus.valPhOffs = 1'b1;
    tick(1'b0, 1'b0);
    cap.delete();
    for (int n = 0; n < 1025; n++) begin
      if (n == 0 || n == 1024) set_hand(32'h7FFF_0065);
      else if (n == 256)       set_hand(32'hFF9B_7FFF);
      else if (n == 512)       set_hand(32'h8001_FF9B);
      tick(1'b1, 1'b0);
    end
    drain();
    chk("period_sample_count", 64'(cap.size()), 64'd1025);
    if (cap.size() >= 1025) begin
      mx = 0;
      for (int n = 0; n < 512; n++) begin
        w   = cap[n];
        w2  = cap[n+512];
        neg = 16'd0 - w[15:0];
        chk("sym_sin_half_period", 64'(w2[15:0]), 64'(neg));
        w2  = cap[n+256];
        chk("sym_cos_quarter_period", 64'(w[31:16]), 64'(w2[15:0]));
      end
      for (int n = 0; n < 1024; n++) begin
        w = cap[n];
        s = int'($signed(w[15:0]));
        if (s < 0) s = -s;
        if (s > mx) mx = s;
        save_cos[n] = w[31:16];
      end
      chk("max_abs_sin", 64'(mx), 64'd32767);
      w  = cap[1024];
      w2 = cap[0];
      chk("wrap_sample_1024", 64'(w), 64'(w2));
    end

    // 90 degree offset: sin stream must equal the previous cos stream.
    bus.phOffs = 32'h4000_0000; bus.valPhOffs = 1'b1;
    tick(1'b0, 1'b1);
    cap.delete();
    for (int n = 0; n < 512; n++) tick(1'b1, 1'b0);
    drain();
    chk("offset_sample_count", 64'(cap.size()), 64'd512);
    if (cap.size() >= 512) begin
      for (int n = 0; n < 512; n++) begin
        w = cap[n];
        chk("offset_sin_eq_prev_cos", 64'(w[15:0]), 64'(save_cos[n]));
      end
    end

    // Gapped enable 1,0,1,1,0.
    bus.phOffs = '0; bus.valPhOffs = 1'b1;
    tick(1'b0, 1'b1);
    cap.delete();
    gap_pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_hand(32'h7FFF_0065);
      tick(gap_pat[i], 1'b0);
    end
    drain();
    chk("gap_sample_count", 64'(cap.size()), 64'd3);

    // syncClr with a same-cycle increment change.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    bus.phInc = 32'h0080_0000; bus.valPhInc = 1'b1;
    set_hand(32'h7FFF_0065);
    tick(1'b1, 1'b1);
    set_hand(32'h7FFE_012E);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    drain();

    // Reset with samples in flight flushes them.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst_n = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    chk("flush_queue_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
